// File: rtl/branch_predict_resolve.sv
// Direct-mapped branch target/direction predictor for IF plus EX-stage
// misprediction detection, table training and performance counters.
module branch_predict_resolve #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        ex_branch,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_actual_taken,
  input  logic [31:0] ex_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] ctrl_count,
  output logic [31:0] mispred_count
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [31:0]         r_ctrl_count;
  logic [31:0]         r_mispred_count;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0]   w_if_tag;
  logic                  w_if_hit;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic [TAG_BITS-1:0]   w_ex_tag;
  logic                  w_ex_hit;
  logic                  w_ex_ctrl;
  logic                  w_redirect;
  logic [31:0]           w_redirect_pc;
  logic [31:0]           w_ex_pc4;

  // Lookup reads pre-update contents; a same-cycle write is not bypassed.
  assign w_if_idx       = if_pc[INDEX_BITS+1:2];
  assign w_if_tag       = if_pc[31:INDEX_BITS+2];
  assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign if_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
  assign if_pred_target = w_if_hit ? r_target[w_if_idx] : 32'd0;

  assign w_ex_idx  = ex_pc[INDEX_BITS+1:2];
  assign w_ex_tag  = ex_pc[31:INDEX_BITS+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_ctrl = ex_branch || ex_jal || ex_jalr;
  assign w_ex_pc4  = ex_pc + 32'd4;

  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = w_ex_pc4;
    if (!ex_stall) begin
      if (ex_branch) begin
        if (ex_actual_taken) begin
          w_redirect    = !ex_pred_taken || (ex_pred_target != ex_target);
          w_redirect_pc = ex_target;
        end else begin
          w_redirect    = ex_pred_taken;
        end
      end else if (ex_jal) begin
        w_redirect    = !ex_pred_taken || (ex_pred_target != ex_target);
        w_redirect_pc = ex_target;
      end else if (ex_jalr) begin
        w_redirect    = 1'b1;
        w_redirect_pc = ex_target;
      end else if (ex_pred_taken) begin
        // Stale entry predicted taken on a non-control instruction.
        w_redirect    = 1'b1;
      end
    end
  end

  assign redirect      = w_redirect;
  assign redirect_pc   = w_redirect_pc;
  assign ctrl_count    = r_ctrl_count;
  assign mispred_count = r_mispred_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_INIT;
      end
      r_ctrl_count    <= '0;
      r_mispred_count <= '0;
    end else if (!ex_stall) begin
      if (ex_branch) begin
        if (w_ex_hit) begin
          if (ex_actual_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            r_target[w_ex_idx] <= ex_target;
          end else if (r_ctr[w_ex_idx] != 2'b00) begin
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
          end
        end else if (ex_actual_taken) begin
          r_valid[w_ex_idx]  <= 1'b1;
          r_tag[w_ex_idx]    <= w_ex_tag;
          r_target[w_ex_idx] <= ex_target;
          r_ctr[w_ex_idx]    <= 2'b10;
        end
      end else if (ex_jal) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= ex_target;
        r_ctr[w_ex_idx]    <= 2'b11;
      end else if (!ex_jalr && ex_pred_taken && w_ex_hit) begin
        r_valid[w_ex_idx] <= 1'b0;
      end
      if (w_ex_ctrl && (r_ctrl_count != 32'hFFFF_FFFF))
        r_ctrl_count <= r_ctrl_count + 32'd1;
      if (w_redirect && (r_mispred_count != 32'hFFFF_FFFF))
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end
endmodule
